// File: rtl/acc_cpu_if.sv
// acc_cpu_if: memory bus between acc_cpu (master) and its memory (slave).
// Strobes are active-low; a strobed access completes on a cycle with mem_ready high.
interface acc_cpu_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 8
);
    logic [DW-1:0] mem_in;
    logic          mem_ready;
    logic          rd_n;
    logic          wr_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_out;

    modport master (
        input  mem_in,
        input  mem_ready,
        output rd_n,
        output wr_n,
        output addr,
        output data_out
    );

    modport slave (
        output mem_in,
        output mem_ready,
        input  rd_n,
        input  wr_n,
        input  addr,
        input  data_out
    );
endinterface

// File: rtl/acc_cpu.sv
// acc_cpu: multi-cycle accumulator CPU sharing one memory port for code and data.
// Define ACC_CPU_WAIT_EN to honour mem_ready wait states; otherwise every access takes one cycle.
module acc_cpu #(
    parameter int unsigned   DW       = 8,
    parameter int unsigned   AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    acc_cpu_if.master     bus,
    output logic          halted,
    output logic [AW-1:0] pc_out,
    output logic [DW-1:0] acc_out,
    output logic          z_flag,
    output logic          c_flag
);
    localparam logic [3:0] OpLda = 4'h1;
    localparam logic [3:0] OpSta = 4'h2;
    localparam logic [3:0] OpAdd = 4'h3;
    localparam logic [3:0] OpSub = 4'h4;
    localparam logic [3:0] OpAnd = 4'h5;
    localparam logic [3:0] OpOr  = 4'h6;
    localparam logic [3:0] OpXor = 4'h7;
    localparam logic [3:0] OpJmp = 4'h8;
    localparam logic [3:0] OpJz  = 4'h9;
    localparam logic [3:0] OpJc  = 4'hA;
    localparam logic [3:0] OpLdi = 4'hB;
    localparam logic [3:0] OpHlt = 4'hF;

    typedef enum logic [1:0] {StFetch, StOperand, StExec, StHalt} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] ar_q, ar_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [3:0]    ir_q, ir_d;
    logic          z_q, z_d;
    logic          c_q, c_d;

    logic          rd_req;
    logic          wr_req;
    logic          done;
    logic [3:0]    opcode;
    logic [AW-1:0] operand_addr;

    assign opcode       = bus.mem_in[DW-1 -: 4];
    assign operand_addr = bus.mem_in[AW-1:0];

    always_comb begin
        rd_req   = 1'b0;
        wr_req   = 1'b0;
        bus.addr = pc_q;
        unique case (state_q)
            StFetch, StOperand: rd_req = 1'b1;
            StExec: begin
                bus.addr = ar_q;
                if (ir_q == OpSta) begin
                    wr_req = 1'b1;
                end else begin
                    rd_req = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Strobes are forced inactive while reset is asserted, even though the state says FETCH.
    assign bus.rd_n     = ~(rd_req & ~rst);
    assign bus.wr_n     = ~(wr_req & ~rst);
    assign bus.data_out = bus.wr_n ? '0 : acc_q;

`ifdef ACC_CPU_WAIT_EN
    assign done = (rd_req | wr_req) & bus.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign done = rd_req | wr_req;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ar_d    = ar_q;
        acc_d   = acc_q;
        ir_d    = ir_q;
        z_d     = z_q;
        c_d     = c_q;
        if (done) begin
            unique case (state_q)
                StFetch: begin
                    ir_d = opcode;
                    pc_d = pc_q + AW'(1);
                    if (opcode == OpHlt) begin
                        state_d = StHalt;
                    end else if (opcode >= OpLda && opcode <= OpLdi) begin
                        state_d = StOperand;
                    end else begin
                        state_d = StFetch;
                    end
                end
                StOperand: begin
                    pc_d    = pc_q + AW'(1);
                    ar_d    = operand_addr;
                    state_d = StFetch;
                    case (ir_q)
                        OpLdi: begin
                            acc_d = bus.mem_in;
                            z_d   = (bus.mem_in == '0);
                        end
                        OpJmp: pc_d = operand_addr;
                        OpJz:  if (z_q) pc_d = operand_addr;
                        OpJc:  if (c_q) pc_d = operand_addr;
                        default: state_d = StExec;
                    endcase
                end
                StExec: begin
                    state_d = StFetch;
                    if (ir_q != OpSta) begin
                        case (ir_q)
                            OpLda: acc_d = bus.mem_in;
                            OpAdd: {c_d, acc_d} = {1'b0, acc_q} + {1'b0, bus.mem_in};
                            OpSub: begin
                                acc_d = acc_q - bus.mem_in;
                                c_d   = (bus.mem_in > acc_q);
                            end
                            OpAnd: acc_d = acc_q & bus.mem_in;
                            OpOr:  acc_d = acc_q | bus.mem_in;
                            OpXor: acc_d = acc_q ^ bus.mem_in;
                            default: ;
                        endcase
                        z_d = (acc_d == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ar_q    <= '0;
            acc_q   <= '0;
            ir_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ar_q    <= ar_d;
            acc_q   <= acc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    assign halted  = (state_q == StHalt);
    assign pc_out  = pc_q;
    assign acc_out = acc_q;
    assign z_flag  = z_q;
    assign c_flag  = c_q;
endmodule

// File: doc/acc_cpu.md
ACC_CPU -- requirements
Module: acc_cpu

Interface
REQ-001 Parameter DW, default 8: data/instruction word width; legal range 8..32.
REQ-002 Parameter AW, default 8: address width; AW SHALL be <= DW.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset, AW bits.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 mem_in  in  DW  read data from memory, sampled at the rising edge that completes a read.
REQ-007 mem_ready  in  1  memory handshake; 1 = current access completes this cycle.
REQ-008 rd_n  out  1  read strobe, active-low.
REQ-009 wr_n  out  1  write strobe, active-low.
REQ-010 addr  out  AW  memory address.
REQ-011 data_out  out  DW  write data; equals acc while wr_n=0, else 0.
REQ-012 halted  out  1  1 while in HALT state.
REQ-013 pc_out / acc_out / z_flag / c_flag  out  AW / DW / 1 / 1  architectural state, observation only.

Function
REQ-014 Instruction word: opcode = mem_in[DW-1:DW-4]; remaining bits ignored.
REQ-015 Opcodes: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 JMP, 9 JZ, A JC, B LDI, F HLT; C/D/E execute as NOP.
REQ-016 Opcodes 1-B are two-word; second word is operand; address operand = operand[AW-1:0].
REQ-017 FSM states FETCH, OPERAND, EXEC, HALT; reset state FETCH.
REQ-018 FETCH: rd_n=0, addr=pc; on completion ir<=opcode, pc<=pc+1; next OPERAND if two-word, HALT if HLT, else FETCH.
REQ-019 OPERAND: rd_n=0, addr=pc; on completion pc<=pc+1, ar<=operand[AW-1:0]; LDI: acc<=operand, Z updated, next FETCH; JMP, and JZ with Z=1, and JC with C=1: pc<=operand[AW-1:0] (overrides increment), next FETCH; untaken JZ/JC -> FETCH; else next EXEC.
REQ-020 EXEC LDA/ADD/SUB/AND/OR/XOR: rd_n=0, addr=ar; on completion acc<=result, next FETCH.
REQ-021 EXEC STA: wr_n=0, addr=ar, data_out=acc; on completion next FETCH; acc and flags unchanged.
REQ-022 ADD: {C,acc} <= acc+operand (DW+1 bits); SUB: acc <= acc-operand mod 2^DW, C=1 iff operand > acc (borrow).
REQ-023 Z <= (new acc == 0) for LDA, LDI, ADD, SUB, AND, OR, XOR; C changed only by ADD/SUB.
REQ-024 PC arithmetic modulo 2^AW; 2^AW-1 increments to 0.
REQ-025 An access "completes" in a cycle where the strobe is low and mem_ready=1; otherwise state, addr, strobes hold unchanged.
REQ-026 rd_n and wr_n SHALL never both be 0; both are 1 in HALT and during reset.
REQ-027 Zero-wait latency: NOP 1 cycle, LDI/jumps 2, LDA/STA/ALU ops 3.
REQ-028 HALT: no memory access, all state held until reset.

Reset
REQ-029 On rst: pc=RESET_PC, acc=0, ir=0, ar=0, Z=0, C=0, state=FETCH, halted=0, rd_n=1, wr_n=1, data_out=0, addr=RESET_PC.
REQ-030 Reset mid-access aborts the access with no state or memory update; first fetch at RESET_PC on first rising edge after deassertion.

Configuration
REQ-031 Macro ACC_CPU_WAIT_EN defined: mem_ready honoured per REQ-025.
REQ-032 ACC_CPU_WAIT_EN undefined: mem_ready port present but ignored; every access completes in one cycle.

Verification
REQ-033 Program LDI 05; ADD [10] with mem[10]=FB -> acc=00, Z=1, C=1 after 5 zero-wait cycles.
REQ-034 LDI 03; SUB [10] with mem[10]=05 -> acc=FE, C=1, Z=0.
REQ-035 LDI 2A; STA 80; HLT -> single cycle with wr_n=0, addr=80, data_out=2A; halted=1, rd_n=wr_n=1 thereafter.
REQ-036 LDI 00; JZ 20 -> next fetch addr=20; LDI 01; JZ 20 -> falls through to pc+2.
REQ-037 ACC_CPU_WAIT_EN, mem_ready low 3 cycles during LDA -> addr/rd_n stable, acc updates on 4th cycle only.
REQ-038 RESET_PC=FE, NOP at FE and FF -> third fetch addr=00; rst pulse mid-EXEC -> next fetch addr=FE, acc=0.
